// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (4-word lines).
// Optional hit/miss counters are enabled with `define DCACHE_PERF_CNT_EN.
module dcache_ctrl #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);
  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e                state_q, state_d;
  logic [NUM_BLOCKS-1:0] valid_q, dirty_q;
  logic [TW-1:0]         tag_q  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];
  logic                  mem_read_q, mem_write_q;

  logic [1:0]    off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          req, hit, victim_dirty, wr_hit, fill;

  assign off = proc_addr[1:0];
  assign idx = proc_addr[IW+1:2];
  assign tag = proc_addr[29:IW+2];

  // A store wins when both request lines are high.
  assign req          = proc_read | proc_write;
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign wr_hit       = (state_q == IDLE) && proc_write && hit;
  assign fill         = (state_q == ALLOCATE) && mem_ready;

  assign proc_stall = (state_q != IDLE) || (req && !hit);
  assign proc_rdata = data_q[idx][{off, 5'b0} +: 32];
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = (state_q == WRITEBACK) ? {tag_q[idx], idx} : proc_addr[29:2];
  assign mem_wdata  = data_q[idx];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req && !hit) state_d = victim_dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ready) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Memory strobes are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= (state_d == ALLOCATE);
      mem_write_q <= (state_d == WRITEBACK);
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill) begin
        data_q[idx] <= mem_rdata;
        tag_q[idx]  <= tag;
      end else if (wr_hit) begin
        data_q[idx][{off, 5'b0} +: 32] <= proc_wdata;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The first IDLE cycle after a fill is the replayed miss, not a fresh hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q <= fill;
      if (state_q == IDLE && req && hit && !replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == IDLE && req && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: line-level cache model plus expected-memory model,
// a latency-programmable memory responder, and queue-based monitors.
module tb_dcache_ctrl;
  localparam int NB = 8;
  localparam int IW = 3;
  localparam int TW = 28 - IW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         proc_read = 1'b0, proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_BLOCKS(NB)) dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_q[$];
  logic [156:0] exp_mem_q[$];

  bit           m_valid [NB];
  bit           m_dirty [NB];
  logic [TW-1:0] m_tag  [NB];
  logic [127:0] m_line  [NB];
  logic [127:0] exp_store [logic [27:0]];
  logic [127:0] mem_store [logic [27:0]];
  int           m_hits = 0, m_misses = 0;

  int mem_lat = 0;
  bit idle_ready = 1'b0;
  int req_cnt = 0;
  int mem_busy = 0;

  function automatic logic [127:0] init_line(logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = {2'(k), 2'b01, la};
    return l;
  endfunction

  function automatic logic [127:0] exp_line(logic [27:0] la);
    return exp_store.exists(la) ? exp_store[la] : init_line(la);
  endfunction

  function automatic logic [127:0] mem_line(logic [27:0] la);
    return mem_store.exists(la) ? mem_store[la] : init_line(la);
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NB; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  // Memory responder: ready after mem_lat+1 cycles of a held request.
  always @(negedge clk) begin
    logic [156:0] e;
    mem_ready = 1'b0;
    if (rst) begin
      req_cnt = 0;
    end else if (mem_read || mem_write) begin
      mem_busy++;
      if (mem_read && mem_write) fail_now("mem_read_and_write_together");
      req_cnt++;
      if (req_cnt > mem_lat) begin
        req_cnt = 0;
        mem_ready = 1'b1;
        if (exp_mem_q.size() == 0) begin
          fail_now("unexpected_mem_transaction");
        end else begin
          e = exp_mem_q.pop_front();
          chk("mem_is_write", 128'(mem_write), 128'(e[156]));
          chk("mem_addr", 128'(mem_addr), 128'(e[155:128]));
          if (mem_write) chk("mem_wdata", mem_wdata, e[127:0]);
        end
        if (mem_write) mem_store[mem_addr] = mem_wdata;
        else mem_rdata = mem_line(mem_addr);
      end
    end else begin
      mem_ready = idle_ready;
    end
  end

  // Load completion monitor.
  always @(negedge clk) begin
    if (!rst && proc_read && !proc_write && !proc_stall) begin
      if (exp_q.size() == 0) fail_now("unexpected_load_completion");
      else chk("proc_rdata", 128'(proc_rdata), 128'(exp_q.pop_front()));
    end
  end

  // Issue one request and hold it until it completes; called at posedge+1.
  task automatic do_req(bit rd, bit wr, logic [29:0] a, logic [31:0] wd, int lat);
    logic [IW-1:0] ix;
    logic [TW-1:0] tg;
    logic [1:0]    off;
    bit            hit, done;
    int            exp_stall, stalls;
    ix = a[IW+1:2];
    tg = a[29:IW+2];
    off = a[1:0];
    hit = m_valid[ix] && (m_tag[ix] == tg);
    exp_stall = 0;
    stalls = 0;
    done = 1'b0;
    mem_lat = lat;
    if (!hit) begin
      m_misses++;
      exp_stall = lat + 2;
      if (m_valid[ix] && m_dirty[ix]) begin
        exp_mem_q.push_back({1'b1, m_tag[ix], ix, m_line[ix]});
        exp_store[{m_tag[ix], ix}] = m_line[ix];
        exp_stall += lat + 1;
      end
      exp_mem_q.push_back({1'b0, a[29:2], 128'h0});
      m_line[ix] = exp_line(a[29:2]);
      m_valid[ix] = 1'b1;
      m_dirty[ix] = 1'b0;
      m_tag[ix] = tg;
    end else begin
      m_hits++;
    end
    if (wr) begin
      m_line[ix][32*off +: 32] = wd;
      m_dirty[ix] = 1'b1;
    end else begin
      exp_q.push_back(m_line[ix][32*off +: 32]);
    end
    proc_read = rd;
    proc_write = wr;
    proc_addr = a;
    proc_wdata = wd;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (!proc_stall) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    if (!done) fail_now("request_timeout");
    else chk("stall_cycles", 128'(stalls), 128'(exp_stall));
    proc_read = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int base;
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 128'(proc_stall), 128'(0));
    chk("reset_mem_read", 128'(mem_read), 128'(0));
    chk("reset_mem_write", 128'(mem_write), 128'(0));
    @(posedge clk);
    #1;

    // Cold read miss, then hit; store hit; conflicting read forces write-back.
    do_req(1'b1, 1'b0, 30'h10, 32'h0, 3);
    do_req(1'b1, 1'b0, 30'h10, 32'h0, 0);
    do_req(1'b0, 1'b1, 30'h11, 32'hDEADBEEF, 2);
    do_req(1'b1, 1'b0, 30'h91, 32'h0, 2);
`ifdef DCACHE_PERF_CNT_EN
    @(negedge clk);
    chk("hit_cnt_directed", 128'(hit_cnt), 128'(m_hits));
    chk("miss_cnt_directed", 128'(miss_cnt), 128'(m_misses));
    @(posedge clk);
    #1;
`endif
    // Clean victim: fetch only.
    do_req(1'b1, 1'b0, 30'h111, 32'h0, 1);

    // mem_ready held in IDLE, then combined read+write hit.
    idle_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    base = mem_busy;
    do_req(1'b1, 1'b1, 30'h112, 32'hCAFEF00D, 0);
    chk("no_mem_activity_on_hit", 128'(mem_busy - base), 128'(0));
    idle_ready = 1'b0;
    do_req(1'b1, 1'b0, 30'h112, 32'h0, 0);

    // Reset during the second ALLOCATE cycle aborts the fill.
    mem_lat = 20;
    proc_read = 1'b1;
    proc_addr = 30'h20;
    @(negedge clk);
    chk("abort_miss_stall", 128'(proc_stall), 128'(1));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_read_before_reset", 128'(mem_read), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    proc_read = 1'b0;
    reset_model();
    exp_mem_q.delete();
    @(negedge clk);
    chk("abort_mem_read_after_reset", 128'(mem_read), 128'(0));
    chk("abort_stall_after_reset", 128'(proc_stall), 128'(0));
    @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 30'h20, 32'h0, 1);
    do_req(1'b1, 1'b0, 30'h112, 32'h0, 1);

    // Random traffic over a small tag set to mix hits, clean and dirty evictions.
    for (int n = 0; n < 300; n++) begin
      int tg, ix, off, kind;
      logic [29:0] a;
      tg = $urandom_range(0, 3);
      ix = $urandom_range(0, NB - 1);
      off = $urandom_range(0, 3);
      kind = $urandom_range(0, 2);
      a = (30'(tg) << (IW + 2)) | (30'(ix) << 2) | 30'(off);
      do_req(kind != 1, kind != 0, a, $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("load_queue_drained", 128'(exp_q.size()), 128'(0));
    chk("mem_queue_drained", 128'(exp_mem_q.size()), 128'(0));
`ifdef DCACHE_PERF_CNT_EN
    chk("hit_cnt_final", 128'(hit_cnt), 128'(m_hits));
    chk("miss_cnt_final", 128'(miss_cnt), 128'(m_misses));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BLOCKS, default 8, meaning the number of direct-mapped lines (power of two, 2..64), each line holding 4 words (128 bits).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these pipeline-side ports:
- proc_read, input, 1, load request.
- proc_write, input, 1, store request.
- proc_addr, input, 30, word address.
- proc_wdata, input, 32, store data.
- proc_rdata, output, 32, load data.
- proc_stall, output, 1, request not complete this cycle.
REQ-005 The block SHALL have these memory-side ports:
- mem_read, output, 1, line fetch request.
- mem_write, output, 1, line write-back request.
- mem_addr, output, 28, line address.
- mem_wdata, output, 128, write-back line.
- mem_rdata, input, 128, fetched line.
- mem_ready, input, 1, one-cycle completion pulse.

Function
REQ-006 proc_addr SHALL split as offset [1:0], index [log2(NUM_BLOCKS)+1:2], tag the remaining upper bits; mem_rdata/mem_wdata word k SHALL occupy bits [32k+31:32k].
REQ-007 Hit SHALL be defined as valid[index] and stored tag equal to the request tag, evaluated combinationally.
REQ-008 The FSM SHALL have states IDLE, WRITEBACK and ALLOCATE.
REQ-009 In IDLE, a request that hits SHALL give proc_stall=0 in the same cycle, with zero added latency.
REQ-010 A read hit SHALL drive proc_rdata combinationally from the addressed word.
REQ-011 A write hit SHALL update the addressed word and set dirty[index] at the next edge.
REQ-012 A miss in IDLE SHALL assert proc_stall combinationally; if the victim line is valid and dirty, the FSM SHALL go to WRITEBACK, otherwise to ALLOCATE.
REQ-013 In WRITEBACK, mem_write SHALL be held high with mem_addr={victim tag,index} and mem_wdata=victim line until mem_ready is sampled high, then the FSM SHALL go to ALLOCATE.
REQ-014 In ALLOCATE, mem_read SHALL be held high with mem_addr=proc_addr[29:2] until mem_ready is sampled high.
REQ-015 On that ALLOCATE edge the line SHALL be written from mem_rdata with valid=1, dirty=0 and tag updated, and the FSM SHALL return to IDLE, where the replayed request hits.
REQ-016 proc_stall SHALL be high in every WRITEBACK and ALLOCATE cycle.
REQ-017 mem_read and mem_write SHALL never be high simultaneously and SHALL be low in IDLE.
REQ-018 mem_ready SHALL be ignored in IDLE.
REQ-019 proc_read and proc_write both high SHALL be treated as a write.
REQ-020 The upstream stage SHALL hold proc_read, proc_write, proc_addr and proc_wdata stable while proc_stall is high; the block does not latch them.
REQ-021 With neither request high, proc_stall SHALL be 0 and no state SHALL change.
REQ-022 Memory latency SHALL be unbounded; the block SHALL wait indefinitely for mem_ready.

Reset
REQ-023 While rst is high at an edge, the FSM SHALL enter IDLE and all valid and dirty bits SHALL clear; data and tag arrays SHALL not be reset.
REQ-024 After reset, outputs SHALL be mem_read=0, mem_write=0 and proc_stall=0 absent a request.
REQ-025 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abort the transaction, deasserting mem_read/mem_write from the cycle after the reset edge, with no dirty data preserved.

Configuration
REQ-026 With macro DCACHE_PERF_CNT_EN defined, the block SHALL add outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0 and wrapping at 2^32.
REQ-027 miss_cnt SHALL increment once per IDLE miss detection.
REQ-028 hit_cnt SHALL increment per IDLE hit, excluding the replay cycle that follows ALLOCATE.
REQ-029 Without DCACHE_PERF_CNT_EN, the block SHALL have neither those ports nor their registers, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then read 0x00000010 with memory returning line {D,C,B,A} after 3 cycles -> exactly one mem_read, mem_addr=0x0000004, proc_stall for 5 cycles, then proc_rdata=A; a second read of the same address -> stall 0.
REQ-031 Write 0xDEADBEEF to 0x00000011 after that fill, then read 0x00000091 (same index 4, different tag) -> mem_write first with mem_addr=0x0000004 and word1=0xDEADBEEF, then mem_read with mem_addr=0x0000024.
REQ-032 Read-miss to a clean victim -> no mem_write; mem_read only.
REQ-033 rst asserted in the 2nd ALLOCATE cycle -> mem_read low the next cycle; a following read of the same address misses again.
REQ-034 Hold mem_ready high in IDLE with no request, then assert proc_read and proc_write together on a hit -> no memory activity, and the store is performed.
REQ-035 With DCACHE_PERF_CNT_EN defined, running REQ-030 then REQ-031 -> miss_cnt=2, hit_cnt=2.
